shift_reg_univ: RTL

- Parametrised universal shift register; successor to the single-bit serial `shift_reg`.
- Register is WIDTH bits wide, with eight operating modes:
  - hold, logical shift left and right, rotate left and right, parallel load, arithmetic shift right, clear.
- Has serial I/O at both ends and a parallel output.
- A shift counter raises `done` after WIDTH shift or rotate steps, so it serves as the serialiser/deserialiser core for later SPI/UART-style blocks.

---
 rtl/shift_reg_univ.sv | 116 +++++++++++
 1 files changed

// File: rtl/shift_reg_univ.sv
// Universal WIDTH-bit shift register with a saturating shift counter.
// Serves as the serialiser/deserialiser core for SPI/UART-style blocks.
module shift_reg_univ #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [2:0]                 mode,
  input  logic                       sin_l,
  input  logic                       sin_r,
  input  logic [WIDTH-1:0]           pin,
  output logic [WIDTH-1:0]           pout,
  output logic                       sout_l,
  output logic                       sout_r,
  output logic [$clog2(WIDTH+1)-1:0] cnt,
  output logic                       done
);

  localparam int CW = $clog2(WIDTH+1);
  localparam logic [CW-1:0] CMAX = CW'(WIDTH);

  typedef enum logic [2:0] {
    M_HOLD  = 3'd0,
    M_SHL   = 3'd1,
    M_SHR   = 3'd2,
    M_ROL   = 3'd3,
    M_ROR   = 3'd4,
    M_LOAD  = 3'd5,
    M_ASR   = 3'd6,
    M_CLEAR = 3'd7
  } mode_t;

  mode_t          op;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_nxt;
  logic [CW-1:0]  cnt_q;
  logic [CW-1:0]  cnt_nxt;
  logic           done_q;
  logic           shift;
  logic           zero;

  assign op = mode_t'(mode);

  always_comb begin
    q_nxt = q;
    shift = 1'b0;
    zero  = 1'b0;
    unique case (op)
      M_HOLD: begin
        q_nxt = q;
      end
      M_SHL: begin
        q_nxt = {q[WIDTH-2:0], sin_r};
        shift = 1'b1;
      end
      M_SHR: begin
        q_nxt = {sin_l, q[WIDTH-1:1]};
        shift = 1'b1;
      end
      M_ROL: begin
        q_nxt = {q[WIDTH-2:0], q[WIDTH-1]};
        shift = 1'b1;
      end
      M_ROR: begin
        q_nxt = {q[0], q[WIDTH-1:1]};
        shift = 1'b1;
      end
      M_LOAD: begin
        q_nxt = pin;
        zero  = 1'b1;
      end
      M_ASR: begin
        q_nxt = {q[WIDTH-1], q[WIDTH-1:1]};
        shift = 1'b1;
      end
      M_CLEAR: begin
        q_nxt = RST_VAL;
        zero  = 1'b1;
      end
      default: begin
        q_nxt = q;
      end
    endcase
  end

  // Counter saturates at WIDTH so long bursts keep done asserted.
  always_comb begin
    cnt_nxt = cnt_q;
    if (zero) begin
      cnt_nxt = '0;
    end else if (shift && (cnt_q != CMAX)) begin
      cnt_nxt = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q      <= RST_VAL;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else if (en) begin
      q      <= q_nxt;
      cnt_q  <= cnt_nxt;
      done_q <= (cnt_nxt == CMAX);
    end
  end

  assign pout   = q;
  assign sout_l = q[WIDTH-1];
  assign sout_r = q[0];
  assign cnt    = cnt_q;
  assign done   = done_q;

endmodule
